// File: rtl/reaction_timer_pkg.sv
// Shared types for the reaction-test datapath and its controlling FSM.
// Packed BCD is used end to end so the seven-segment driver needs no conversion.
package reaction_pkg;
  typedef logic [3:0]  bcd_digit_t;
  typedef logic [15:0] bcd4_t;

  localparam bcd4_t BCD_MAX = 16'h9999;
  localparam int    BIN_W   = 14;
endpackage

// File: rtl/reaction_timer_if.sv
// FSM-to-datapath bundle: level controls from the FSM, BCD results back to the display side.
interface reaction_timer_if;
  import reaction_pkg::*;

  logic  time_clr;
  logic  time_en;
  logic  rs_en;
  logic  time_late;
  bcd4_t live_bcd;
  bcd4_t result_bcd;
  logic  result_valid;
  bcd4_t best_bcd;
  logic  best_valid;

  modport master (
    output time_clr, time_en, rs_en,
    input  time_late, live_bcd, result_bcd, result_valid, best_bcd, best_valid
  );

  modport slave (
    input  time_clr, time_en, rs_en,
    output time_late, live_bcd, result_bcd, result_valid, best_bcd, best_valid
  );
endinterface

// File: rtl/reaction_timer_bcd_digit.sv
// One decimal digit of the live-count cascade; holds when the whole counter is saturated.
module bcd_digit
  import reaction_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic       sat,
  output bcd_digit_t q,
  output logic       carry
);

  bcd_digit_t q_q, q_d;

  // Next digit value: clear wins, then increment with 9->0 wrap.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (inc && !sat) begin
      if (q_q == 4'd9) begin
        q_d = 4'd0;
      end else begin
        q_d = q_q + 4'd1;
      end
    end else begin
      q_d = q_q;
    end
  end

  // Digit register.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = inc & ~sat & ~clr & (q_q == 4'd9);

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time datapath: ms prescaler, BCD live count with binary shadow, late flag,
// result latch on rs_en rising edge and session-best tracking.
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int CLKS_PER_MS = 100000,
  parameter int LATE_MS     = 1000,
  parameter int MAX_MS      = 9999
) (
  input  logic             clk,
  input  logic             rst,
  reaction_timer_if.slave  bus
);

  localparam int                PW       = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0]     PRE_LAST = PW'(CLKS_PER_MS - 1);
  localparam logic [BIN_W-1:0]  LATE_BIN = BIN_W'(LATE_MS);
  localparam logic [BIN_W-1:0]  MAX_BIN  = BIN_W'(MAX_MS);

  logic [PW-1:0]    presc_q, presc_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BIN_W-1:0] best_bin_q, best_bin_d;
  logic             late_q, late_d;
  logic             rs_q;
  logic             result_valid_q;
  logic             best_valid_q, best_valid_d;
  bcd4_t            result_q, result_d;
  bcd4_t            best_q, best_d;
  bcd4_t            live_s;
  logic             tick_s, sat_s, rs_rise_s;
  logic [3:0]       carry_s;
  logic             carry_unused_s;

  assign tick_s    = bus.time_en & ~bus.time_clr & (presc_q == PRE_LAST);
  assign sat_s     = (bin_q >= MAX_BIN);
  assign rs_rise_s = bus.rs_en & ~rs_q;

  // The thousands-digit carry can never fire because saturation stops the count first.
  assign carry_unused_s = carry_s[3];

  for (genvar g = 0; g < 4; g++) begin : g_digit
    logic inc_s;
    if (g == 0) begin : g_lsd
      assign inc_s = tick_s;
    end else begin : g_upper
      assign inc_s = carry_s[g-1];
    end
    bcd_digit u_digit (
      .clk   (clk),
      .rst   (rst),
      .clr   (bus.time_clr),
      .inc   (inc_s),
      .sat   (sat_s),
      .q     (live_s[4*g +: 4]),
      .carry (carry_s[g])
    );
  end

  // Prescaler, binary shadow and sticky late flag; clear beats enable.
  always_comb begin
    presc_d = presc_q;
    bin_d   = bin_q;
    late_d  = late_q;
    if (bus.time_clr) begin
      presc_d = '0;
      bin_d   = '0;
      late_d  = 1'b0;
    end else begin
      if (bus.time_en) begin
        presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + PW'(1);
      end else begin
        presc_d = presc_q;
      end
      if (tick_s && !sat_s) begin
        bin_d = bin_q + 14'd1;
      end else begin
        bin_d = bin_q;
      end
      late_d = late_q | (bin_d >= LATE_BIN);
    end
  end

  // Result and best capture the live value as it stands before this edge's update.
  always_comb begin
    result_d     = result_q;
    best_d       = best_q;
    best_bin_d   = best_bin_q;
    best_valid_d = best_valid_q;
    if (rs_rise_s) begin
      result_d = live_s;
      if (!best_valid_q || (bin_q < best_bin_q)) begin
        best_d       = live_s;
        best_bin_d   = bin_q;
        best_valid_d = 1'b1;
      end else begin
        best_valid_d = best_valid_q;
      end
    end else begin
      result_d = result_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q        <= '0;
      bin_q          <= '0;
      late_q         <= 1'b0;
      rs_q           <= 1'b0;
      result_q       <= 16'h0000;
      result_valid_q <= 1'b0;
      best_q         <= BCD_MAX;
      best_bin_q     <= BIN_W'(16'h3FFF);
      best_valid_q   <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      bin_q          <= bin_d;
      late_q         <= late_d;
      rs_q           <= bus.rs_en;
      result_q       <= result_d;
      result_valid_q <= rs_rise_s;
      best_q         <= best_d;
      best_bin_q     <= best_bin_d;
      best_valid_q   <= best_valid_d;
    end
  end

  assign bus.time_late    = late_q;
  assign bus.live_bcd     = live_s;
  assign bus.result_bcd   = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.best_bcd     = best_q;
  assign bus.best_valid   = best_valid_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer: directed scenarios plus random control traffic, checked against
// an elapsed-cycle arithmetic model and a scoreboard of expected result latches.
module tb_reaction_timer;
  import reaction_pkg::*;

  localparam int CPM  = 4;
  localparam int LATE = 1000;
  localparam int MAXM = 9999;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reaction_timer_if bus ();

  reaction_timer #(.CLKS_PER_MS(CPM), .LATE_MS(LATE), .MAX_MS(MAXM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    bcd4_t result;
    bcd4_t best;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Model: enabled cycles since last clear; ms is derived from it by division.
  int   m_cyc   = 0;
  int   m_best  = 9999;
  bit   m_bv    = 1'b0;
  bit   m_rs    = 1'b0;
  int   m_res   = 0;
  bit   m_rv    = 1'b0;
  bit   m_known = 1'b0;

  function automatic bcd4_t to_bcd(input int v);
    to_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int model_ms();
    int ms;
    ms = m_cyc / CPM;
    model_ms = (ms > MAXM) ? MAXM : ms;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    n_checks++;
    if (act === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  // One clock: compare current outputs, drive inputs, advance model across the edge.
  task automatic step(input bit r, input bit clr, input bit en, input bit rs);
    int   ms;
    exp_t e;
    @(negedge clk);
    if (m_known) begin
      ms = model_ms();
      check("live_bcd",     bus.live_bcd,            to_bcd(ms));
      check("time_late",    16'(bus.time_late),      16'(ms >= LATE));
      check("result_bcd",   bus.result_bcd,          to_bcd(m_res));
      check("result_valid", 16'(bus.result_valid),   16'(m_rv));
      check("best_bcd",     bus.best_bcd,            m_bv ? to_bcd(m_best) : 16'h9999);
      check("best_valid",   16'(bus.best_valid),     16'(m_bv));
    end
    rst          = r;
    bus.time_clr = clr;
    bus.time_en  = en;
    bus.rs_en    = rs;
    @(posedge clk);
    ms   = model_ms();
    m_rv = 1'b0;
    if (r) begin
      m_cyc   = 0;
      m_best  = 9999;
      m_bv    = 1'b0;
      m_rs    = 1'b0;
      m_res   = 0;
      m_known = 1'b1;
    end else begin
      if (rs && !m_rs) begin
        m_res = ms;
        m_rv  = 1'b1;
        if (!m_bv || ms < m_best) begin
          m_best = ms;
          m_bv   = 1'b1;
        end
        e.result = to_bcd(ms);
        e.best   = to_bcd(m_best);
        exp_q.push_back(e);
      end
      m_rs = rs;
      if (clr) begin
        m_cyc = 0;
      end else if (en && m_cyc < 1000000) begin
        m_cyc++;
      end
    end
  endtask

  task automatic run_ms(input int ms);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < ms * CPM; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Scoreboard monitor: every result_valid pulse must match a queued latch.
  always @(negedge clk) begin
    exp_t e;
    if (bus.result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_valid", 16'd1, 16'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", bus.result_bcd, e.result);
        check("sb_best",   bus.best_bcd,   e.best);
      end
    end
  end

  initial begin
    bus.time_clr = 1'b0;
    bus.time_en  = 1'b0;
    bus.rs_en    = 1'b0;

    // Reset, then check reset values.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // 1000 enabled cycles -> 250 ms, then hold.
    run_ms(250);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Clear beats enable.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0);

    // Late threshold and saturation.
    run_ms(1000);
    for (int i = 0; i < (MAXM - 1000) * CPM + 40; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Result latch and best tracking.
    run_ms(250); step(1'b0, 1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b0, 1'b0);
    run_ms(180); step(1'b0, 1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b0, 1'b0);
    run_ms(300); step(1'b0, 1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b0, 1'b0);
    run_ms(500);
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Latch coinciding with clear, and with a tick.
    run_ms(90);  step(1'b0, 1'b1, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b0, 1'b0);
    run_ms(40);
    for (int i = 0; i < CPM - 1; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1); step(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-count at 0123 loses best.
    run_ms(123);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Random control traffic.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(1999, 0) == 0,
           $urandom_range(63, 0) == 0,
           $urandom_range(3, 0) != 0,
           (m_rs ? ($urandom_range(3, 0) != 0) : ($urandom_range(15, 0) == 0)));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    check("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
